// File: rtl/alpha_ced_stage.sv
// Forward alpha permutation stage: rotates each state row left by one column, buffers
// results in a 2-entry FIFO and checks per-row XOR parity at the output.
module alpha_ced_stage #(
  parameter int unsigned CNT_W    = 4,
  parameter bit          EN_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0][3:0][7:0]  in_state,
  input  logic [7:0]            fault_inj,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0][3:0][7:0]  out_state,
  output logic                  ced_err,
  output logic                  err_sticky,
  output logic [CNT_W-1:0]      err_cnt
);

  typedef logic [3:0][3:0][7:0] state_t;
  typedef logic [3:0][7:0]      par_t;

  state_t            data_q [2];
  par_t              par_q  [2];
  state_t            last_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              in_ready_q;
  logic              ced_err_q, err_sticky_q;
  logic [CNT_W-1:0]  err_cnt_q;

  state_t perm;
  par_t   par_in, par_out;
  logic   accept, deliver, mismatch;

  always_comb begin
    perm   = '0;
    par_in = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        perm[r][c] = in_state[r][(c + 1) % 4];
      end
      par_in[r] = in_state[r][0] ^ in_state[r][1] ^ in_state[r][2] ^ in_state[r][3];
    end
    // Test-only corruption; the predicted parity deliberately ignores it.
    perm[0][0] = in_state[0][1] ^ fault_inj;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_state = out_valid ? data_q[rd_ptr_q] : last_q;
  assign accept    = in_valid & in_ready_q;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    par_out = '0;
    for (int r = 0; r < 4; r++) begin
      par_out[r] = out_state[r][0] ^ out_state[r][1] ^ out_state[r][2] ^ out_state[r][3];
    end
  end

  assign mismatch = deliver && (par_out != par_q[rd_ptr_q]);

  always_comb begin
    count_d = count_q;
    unique case ({accept, deliver})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        par_q[i]  <= '0;
      end
      last_q       <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      in_ready_q   <= 1'b1;
      ced_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      if (accept) begin
        data_q[wr_ptr_q] <= perm;
        par_q[wr_ptr_q]  <= par_in;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (deliver) begin
        last_q   <= data_q[rd_ptr_q];
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      in_ready_q <= (count_d < 2'd2);
      if (EN_CHECK) begin
        ced_err_q <= mismatch;
        if (mismatch) begin
          err_sticky_q <= 1'b1;
          if (err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

  assign ced_err    = ced_err_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_alpha_ced_stage.sv
// Scoreboard bench for alpha_ced_stage: a driver issues directed and random beats, a negedge
// monitor compares every output against a row-rotation model kept in a queue.
module tb_alpha_ced_stage;

  typedef logic [3:0][3:0][7:0] state_t;
  typedef struct {
    state_t data;
    bit     mism;
  } exp_t;

  localparam int unsigned CntW   = 4;
  localparam int          CntMax = (1 << CntW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready, in_ready_nc;
  state_t           in_state;
  logic [7:0]       fault_inj;
  logic             out_valid, out_valid_nc;
  logic             out_ready;
  state_t           out_state, out_state_nc;
  logic             ced_err, ced_err_nc;
  logic             err_sticky, err_sticky_nc;
  logic [CntW-1:0]  err_cnt, err_cnt_nc;

  int checks = 0;
  int errors = 0;

  alpha_ced_stage #(.CNT_W(CntW), .EN_CHECK(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .fault_inj  (fault_inj),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .ced_err    (ced_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  alpha_ced_stage #(.CNT_W(CntW), .EN_CHECK(1'b0)) dut_nc (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready_nc),
    .in_state   (in_state),
    .fault_inj  (fault_inj),
    .out_valid  (out_valid_nc),
    .out_ready  (out_ready),
    .out_state  (out_state_nc),
    .ced_err    (ced_err_nc),
    .err_sticky (err_sticky_nc),
    .err_cnt    (err_cnt_nc)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: each output row is the input row rotated left by one byte.
  function automatic state_t rotate(input state_t s, input logic [7:0] f);
    state_t o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[r][c] = s[r][(c + 1) % 4];
      end
    end
    o[0][0] = o[0][0] ^ f;
    return o;
  endfunction

  exp_t exp_q[$];
  bit   armed = 1'b0;
  bit   exp_ced = 1'b0;
  bit   exp_sticky = 1'b0;
  int   exp_cnt = 0;

  always @(negedge clk) begin
    if (armed) begin
      check("in_ready",   {127'd0, in_ready},   {127'd0, (exp_q.size() < 2)});
      check("out_valid",  {127'd0, out_valid},  {127'd0, (exp_q.size() != 0)});
      check("ced_err",    {127'd0, ced_err},    {127'd0, exp_ced});
      check("err_sticky", {127'd0, err_sticky}, {127'd0, exp_sticky});
      check("err_cnt",    {124'd0, err_cnt},    128'(exp_cnt));
      check("nc_errors",  {123'd0, ced_err_nc, err_sticky_nc, err_cnt_nc}, 128'd0);
      check("nc_out_valid", {127'd0, out_valid_nc}, {127'd0, out_valid});
      if (exp_q.size() != 0) begin
        check("out_state", out_state, exp_q[0].data);
        check("nc_out_state", out_state_nc, exp_q[0].data);
      end
    end
    // Predict the effect of the coming edge.
    if (rst) begin
      armed      = 1'b1;
      exp_q.delete();
      exp_ced    = 1'b0;
      exp_sticky = 1'b0;
      exp_cnt    = 0;
    end else if (armed) begin
      exp_ced = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got out_valid=1 expected empty at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.mism) begin
            exp_ced    = 1'b1;
            exp_sticky = 1'b1;
            if (exp_cnt < CntMax) exp_cnt++;
          end
        end
      end
      if (in_valid && (exp_q.size() < 2 || in_ready)) begin
        if (in_ready) begin
          exp_t n;
          n.data = rotate(in_state, fault_inj);
          n.mism = (fault_inj != 8'h00);
          exp_q.push_back(n);
        end
      end
    end
  end

  task automatic push(input state_t s, input logic [7:0] f);
    bit done = 1'b0;
    in_valid  = 1'b1;
    in_state  = s;
    fault_inj = f;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
    in_valid  = 1'b0;
    fault_inj = 8'h00;
  endtask

  function automatic state_t rand_state();
    state_t s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s[r][c] = 8'($urandom);
      end
    end
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    state_t s;
    rst = 1'b1; in_valid = 1'b0; in_state = '0; fault_inj = 8'h00; out_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);

    // T1: nibble-coded state through an empty stage
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s[r][c] = {4'(r), 4'(c)};
      end
    end
    out_ready = 1'b1;
    push(s, 8'h00);
    idle(3);

    // T2: backpressure, C stalls until out_ready rises
    out_ready = 1'b0;
    push(rand_state(), 8'h00);
    push(rand_state(), 8'h00);
    fork
      push(rand_state(), 8'h00);
      begin
        idle(5);
        out_ready = 1'b1;
      end
    join
    idle(4);

    // T3: back-to-back streaming
    for (int i = 0; i < 16; i++) push(rand_state(), 8'h00);
    idle(3);

    // T4: single faulted beat followed by clean beats
    push(rand_state(), 8'h01);
    for (int i = 0; i < 4; i++) push(rand_state(), 8'h00);
    idle(3);

    // T5: saturate the error counter with random backpressure
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'($urandom_range(0, 1)) | (i[1:0] == 2'd0);
      push(rand_state(), 8'($urandom_range(1, 255)));
    end
    out_ready = 1'b1;
    idle(4);

    // T6: reset with a full buffer, then one beat with 1-cycle latency
    out_ready = 1'b0;
    push(rand_state(), 8'h01);
    push(rand_state(), 8'h00);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    out_ready = 1'b1;
    push(rand_state(), 8'h00);
    idle(3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_state  = rand_state();
      fault_inj = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      out_ready = 1'($urandom_range(0, 3) != 0);
      idle(1);
    end
    in_valid  = 1'b0;
    fault_inj = 8'h00;
    out_ready = 1'b1;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
